// File: rtl/sll_shifter_pkg.sv
// Shared ALU types and constants used by the logical-left-shift datapath.
package sll_shifter_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_SHW   = 5;

    typedef logic [ALU_WIDTH-1:0] word_t;
    typedef logic [ALU_SHW-1:0]   shamt_t;

endpackage : sll_shifter_pkg

// File: rtl/sll_stage.sv
// One barrel-shifter level: conditionally shifts left by a fixed distance with zero fill.
module sll_stage
    import sll_shifter_pkg::*;
#(
    parameter int DIST = 1
) (
    input  word_t in,
    input  logic  en,
    output word_t out
);

    word_t shifted;

    assign shifted = {in[ALU_WIDTH-1-DIST:0], {DIST{1'b0}}};
    assign out     = en ? shifted : in;

endmodule : sll_stage

// File: rtl/sll_shifter.sv
// Registered 32-bit logical left shifter: 5-level barrel chain feeding output/valid flops.
module sll_shifter
    import sll_shifter_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = ALU_SHW
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out
);

    // stage_data[0] is the operand; stage_data[SHW] is the fully shifted word.
    word_t stage_data [0:SHW];

    assign stage_data[0] = data_in;

    // Largest distance first: level gi shifts by 2^(SHW-1-gi) under shamt[SHW-1-gi].
    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            sll_stage #(
                .DIST(1 << (SHW - 1 - gi))
            ) u_stage (
                .in  (stage_data[gi]),
                .en  (shamt[SHW-1-gi]),
                .out (stage_data[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= stage_data[SHW];
            end
        end
    end

endmodule : sll_shifter

// File: tb/tb_sll_shifter.sv
// Self-checking bench for sll_shifter: directed cases plus randomized traffic vs a reference model.
module tb_sll_shifter;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        out_valid;
    logic [31:0] data_out;

    int tests;
    int fails;

    // Reference model state: what the outputs should show after the latest edge.
    logic [31:0] exp_data;
    logic        exp_valid;

    sll_shifter #(
        .WIDTH(32),
        .SHW  (5)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .data_in  (data_in),
        .shamt    (shamt),
        .out_valid(out_valid),
        .data_out (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: multiply by 2^s and keep the low 32 bits.
    function automatic logic [31:0] ref_sll(input logic [31:0] d, input logic [4:0] s);
        longint unsigned prod;
        prod = longint'(d) * (64'd1 << s);
        return prod[31:0];
    endfunction

    // Apply inputs at a falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic v, input logic [31:0] d, input logic [4:0] s);
        in_valid = v;
        data_in  = d;
        shamt    = s;
        if (reset_n && v) exp_data = ref_sll(d, s);
        if (reset_n) exp_valid = v;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        data_in  = 32'hFFFF_FFFF;
        shamt    = 5'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests++;
        if (data_out !== 32'h0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: data_out=%h out_valid=%b expected 00000000/0", data_out, out_valid);
        end
        reset_n   = 1'b1;
        exp_data  = 32'h0;
        exp_valid = 1'b0;
        step(1'b1, 32'hFFFF_FFFF, 5'd3);
        tests++;
        if (data_out !== 32'hFFFF_FFF8 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_edge: data_out=%h out_valid=%b expected fffffff8/1", data_out, out_valid);
        end
        $display("[TB] reset: data_out=%h out_valid=%b", data_out, out_valid);
    endtask

    task automatic test_sweep();
        for (int s = 1; s <= 15; s++) begin
            logic [31:0] want;
            step(1'b1, 32'hAFAF_0800, 5'(s));
            want = ref_sll(32'hAFAF_0800, 5'(s));
            if (s == 1)  want = 32'h5F5E_1000;
            if (s == 4)  want = 32'hFAF0_8000;
            if (s == 15) want = 32'h8400_0000;
            tests++;
            if (data_out !== want || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL sweep_s%0d: data_out=%h out_valid=%b expected %h/1", s, data_out, out_valid, want);
            end
            $display("[TB] sweep shamt=%0d data_out=%h", s, data_out);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] d_tab [3];
        logic [4:0]  s_tab [3];
        logic [31:0] w_tab [3];
        d_tab = '{32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFE};
        s_tab = '{5'd0, 5'd31, 5'd31};
        w_tab = '{32'h1234_5678, 32'h8000_0000, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            // Preload a nonzero value so a zero result is a genuine capture.
            step(1'b1, 32'h5555_AAAA, 5'd0);
            step(1'b1, d_tab[i], s_tab[i]);
            tests++;
            if (data_out !== w_tab[i] || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL boundary_%0d: data_out=%h out_valid=%b expected %h/1", i, data_out, out_valid, w_tab[i]);
            end
            $display("[TB] boundary data_in=%h shamt=%0d data_out=%h", d_tab[i], s_tab[i], data_out);
        end
    endtask

    task automatic test_single_stage();
        for (int k = 0; k < 5; k++) begin
            logic [4:0]  s;
            logic [31:0] want;
            s    = 5'(1 << k);
            want = 32'h1 << (1 << k);
            step(1'b1, 32'h0000_0001, s);
            tests++;
            if (data_out !== want) begin
                fails++;
                $display("FAIL stage_%0d: data_out=%h expected %h", s, data_out, want);
            end
            $display("[TB] stage shamt=%0d data_out=%h", s, data_out);
        end
    endtask

    task automatic test_hold_valid();
        logic        v_tab [4];
        logic [31:0] d_tab [4];
        logic [4:0]  s_tab [4];
        logic [31:0] w_tab [4];
        v_tab = '{1'b1, 1'b0, 1'b0, 1'b1};
        d_tab = '{32'h0000_00F3, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1357_9BDF};
        s_tab = '{5'd8, 5'd4, 5'd12, 5'd2};
        w_tab = '{32'h0000_F300, 32'h0000_F300, 32'h0000_F300, 32'h4D5E_6F7C};
        for (int i = 0; i < 4; i++) begin
            step(v_tab[i], d_tab[i], s_tab[i]);
            tests++;
            if (data_out !== w_tab[i] || out_valid !== v_tab[i]) begin
                fails++;
                $display("FAIL hold_%0d: data_out=%h out_valid=%b expected %h/%b",
                         i, data_out, out_valid, w_tab[i], v_tab[i]);
            end
            $display("[TB] hold cycle %0d data_out=%h out_valid=%b", i, data_out, out_valid);
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            logic        v;
            logic [31:0] d;
            logic [4:0]  s;
            v = ($urandom_range(0, 3) != 0);
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            step(v, d, s);
            tests++;
            if (data_out !== exp_data || out_valid !== exp_valid) begin
                fails++;
                $display("FAIL random_%0d: data_out=%h out_valid=%b expected %h/%b",
                         i, data_out, out_valid, exp_data, exp_valid);
            end
            $display("[TB] random %0d v=%b d=%h s=%0d data_out=%h", i, v, d, s, data_out);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'h0F0F_1234, 5'd4);
        in_valid = 1'b1;
        data_in  = 32'hC0DE_0001;
        shamt    = 5'd0;
        @(posedge clock);
        #2;
        tests++;
        if (data_out !== 32'hC0DE_0001 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL async_pre: data_out=%h out_valid=%b expected c0de0001/1", data_out, out_valid);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (data_out !== 32'h0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_clear: data_out=%h out_valid=%b expected 00000000/0", data_out, out_valid);
        end
        $display("[TB] async reset: data_out=%h out_valid=%b", data_out, out_valid);
        @(posedge clock);
        @(negedge clock);
        tests++;
        if (data_out !== 32'h0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_held: data_out=%h out_valid=%b expected 00000000/0", data_out, out_valid);
        end
        reset_n   = 1'b1;
        exp_data  = 32'h0;
        exp_valid = 1'b0;
        test_random(40);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        shamt     = '0;
        exp_data  = '0;
        exp_valid = 1'b0;
        @(negedge clock);
        test_reset();
        test_sweep();
        test_boundary();
        test_single_stage();
        test_hold_valid();
        test_random(150);
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule : tb_sll_shifter
